// File: rtl/lsu_ram_bridge.sv
// rtl/lsu_ram_bridge.sv - byte/half/word load-store bridge onto a word-wide RAM; optional range check via LSU_RANGE_CHECK_EN
module lsu_ram_bridge #(
    parameter int RAM_SIZE = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        ram_write_enable,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_write_data,
    input  logic [31:0] ram_read_data
);

`ifdef LSU_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    localparam logic [29:0] RAM_WORDS = 30'(RAM_SIZE);

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  lat_size;
    logic [1:0]  lat_off;
    logic        lat_unsigned;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] rdata_q;
    logic [31:0] wdata_q;

    logic        req_fire;
    logic        req_err;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready        = (state == IDLE);
    assign req_fire         = req_valid & req_ready;
    assign rsp_valid        = (state == RESP);
    assign rsp_error        = rsp_valid & err_q;
    assign rsp_rdata        = rdata_q;
    // Decoded from state so an asynchronous reset drops the strobe immediately.
    assign ram_write_enable = (state == WRITE);
    assign ram_addr         = addr_q;
    assign ram_write_data   = wdata_q;

    // Classify the incoming request: misalignment, bad size, optional range violation.
    always_comb begin
        req_err = 1'b0;
        if (req_size == SIZE_BAD)
            req_err = 1'b1;
        if ((req_size == SIZE_HALF) && req_addr[0])
            req_err = 1'b1;
        if ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
            req_err = 1'b1;
        if (RANGE_CHECK && (req_addr[31:2] >= RAM_WORDS))
            req_err = 1'b1;
    end

    // Select the addressed lane of the RAM word and sign/zero-extend it.
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b   = ram_read_data[{lat_off, 3'b000} +: 8];
        lane_h   = lat_off[1] ? ram_read_data[31:16] : ram_read_data[15:0];
        load_ext = ram_read_data;
        case (lat_size)
            SIZE_BYTE: load_ext = {{24{~lat_unsigned & lane_b[7]}}, lane_b};
            SIZE_HALF: load_ext = {{16{~lat_unsigned & lane_h[15]}}, lane_h};
            default:   load_ext = ram_read_data;
        endcase
    end

    // Merge the right-aligned store data into the addressed lane of the current word.
    always_comb begin
        merged = ram_read_data;
        if (lat_size == SIZE_BYTE)
            merged[{lat_off, 3'b000} +: 8] = wdata_q[7:0];
        else if (lat_off[1])
            merged[31:16] = wdata_q[15:0];
        else
            merged[15:0] = wdata_q[15:0];
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    if (req_err)
                        state_next = RESP;
                    else if (!req_write)
                        state_next = LOAD;
                    else if (req_size == SIZE_WORD)
                        state_next = WRITE;
                    else
                        state_next = RMW;
                end
            end
            LOAD:    state_next = RESP;
            RMW:     state_next = WRITE;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus request latch, load capture and read-modify-write merge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lat_size     <= 2'b00;
            lat_off      <= 2'b00;
            lat_unsigned <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= 32'h0;
            rdata_q      <= 32'h0;
            wdata_q      <= 32'h0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        lat_size     <= req_size;
                        lat_off      <= req_addr[1:0];
                        lat_unsigned <= req_unsigned;
                        err_q        <= req_err;
                        addr_q       <= {req_addr[31:2], 2'b00};
                        rdata_q      <= 32'h0;
                        wdata_q      <= req_wdata;
                    end
                end
                LOAD:    rdata_q <= load_ext;
                RMW:     wdata_q <= merged;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ram_bridge.sv
// tb/tb_lsu_ram_bridge.sv - scoreboard bench for lsu_ram_bridge with a behavioural word RAM
module tb_lsu_ram_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        ram_write_enable;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic [31:0] ram_read_data;

    logic [31:0] mem [0:63];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int we_seen = 0;
    int txn_we = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          we_lat;
    } exp_t;

    exp_t exp_q[$];

    lsu_ram_bridge #(.RAM_SIZE(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_error        (rsp_error),
        .ram_write_enable (ram_write_enable),
        .ram_addr         (ram_addr),
        .ram_write_data   (ram_write_data),
        .ram_read_data    (ram_read_data)
    );

    always #5 clk = ~clk;

    assign ram_read_data = mem[ram_addr[7:2]];

    always @(posedge clk) begin
        if (ram_write_enable)
            mem[ram_addr[7:2]] <= ram_write_data;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready)
            acc_cyc <= cyc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ram_write_enable) begin
            we_seen++;
            txn_we++;
            if (exp_q.size() == 0) begin
                check("we_unexpected", 32'd1, 32'd0);
            end else begin
                check("we_expected", 32'd1, 32'(exp_q[0].we));
                check("we_addr", ram_addr, exp_q[0].waddr);
                check("we_data", ram_write_data, exp_q[0].wdata);
                check("we_latency", 32'(cyc - acc_cyc), 32'(exp_q[0].we_lat));
            end
        end
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_error", 32'(rsp_error), 32'(e.err));
                check("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
                check("we_pulses", 32'(txn_we), e.we ? 32'd1 : 32'd0);
            end
            txn_we = 0;
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int lat,
                         input logic ewe, input logic [31:0] ewa, input logic [31:0] ewd,
                         input int wlat);
        exp_t e;
        e.rdata = er;
        e.err = ee;
        e.lat = lat;
        e.we = ewe;
        e.waddr = ewa;
        e.wdata = ewd;
        e.we_lat = wlat;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_size = sz;
        req_unsigned = uns;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("rsp_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic reset_during(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] keep, input string tag);
        int ws;
        ws = we_seen;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = sz;
        req_unsigned = 1'b0;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_we_low"}, 32'(ram_write_enable), 32'd0);
        check({tag, "_rsp_low"}, 32'(rsp_valid), 32'd0);
        check({tag, "_ram_addr"}, ram_addr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_mem_kept"}, mem[a[7:2]], keep);
        check({tag, "_no_write"}, 32'(we_seen - ws), 32'd0);
        check({tag, "_idle"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_error", 32'(rsp_error), 32'd0);
        check("reset_we", 32'(ram_write_enable), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_ram_addr", ram_addr, 32'h0);
        check("reset_ram_wdata", ram_write_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // preload through word stores
        issue(1, 2'b10, 0, 32'h08, 32'h8899AABB, 32'h0, 0, 2, 1, 32'h08, 32'h8899AABB, 1);
        issue(1, 2'b10, 0, 32'h0C, 32'h11223344, 32'h0, 0, 2, 1, 32'h0C, 32'h11223344, 1);

        // byte and half loads, signed and unsigned
        issue(0, 2'b00, 0, 32'h0B, 32'h0, 32'hFFFFFF88, 0, 2, 0, 32'h0, 32'h0, 0);
        issue(0, 2'b00, 1, 32'h0B, 32'h0, 32'h00000088, 0, 2, 0, 32'h0, 32'h0, 0);
        issue(0, 2'b00, 0, 32'h08, 32'h0, 32'hFFFFFFBB, 0, 2, 0, 32'h0, 32'h0, 0);
        issue(0, 2'b01, 0, 32'h0A, 32'h0, 32'hFFFF8899, 0, 2, 0, 32'h0, 32'h0, 0);
        issue(0, 2'b01, 1, 32'h08, 32'h0, 32'h0000AABB, 0, 2, 0, 32'h0, 32'h0, 0);

        // half store read-modify-write, then read back
        issue(1, 2'b01, 0, 32'h0A, 32'h00001234, 32'h0, 0, 3, 1, 32'h08, 32'h1234AABB, 2);
        issue(0, 2'b10, 0, 32'h08, 32'h0, 32'h1234AABB, 0, 2, 0, 32'h0, 32'h0, 0);

        // word store, read back, byte merge into it
        issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'h10, 32'hDEADBEEF, 1);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0, 32'h0, 32'h0, 0);
        issue(1, 2'b00, 0, 32'h11, 32'hFFFFFF55, 32'h0, 0, 3, 1, 32'h10, 32'hDEAD55EF, 2);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0, 2, 0, 32'h0, 32'h0, 0);

        // misaligned and bad-size errors
        issue(0, 2'b01, 0, 32'h01, 32'h0, 32'h0, 1, 1, 0, 32'h0, 32'h0, 0);
        issue(1, 2'b10, 0, 32'h06, 32'h12345678, 32'h0, 1, 1, 0, 32'h0, 32'h0, 0);
        issue(0, 2'b11, 0, 32'h00, 32'h0, 32'h0, 1, 1, 0, 32'h0, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h0C, 32'h0, 32'h11223344, 0, 2, 0, 32'h0, 32'h0, 0);

        // first word beyond the RAM
`ifdef LSU_RANGE_CHECK_EN
        issue(1, 2'b10, 0, 32'h80, 32'hCAFEF00D, 32'h0, 1, 1, 0, 32'h0, 32'h0, 0);
`else
        issue(1, 2'b10, 0, 32'h80, 32'hCAFEF00D, 32'h0, 0, 2, 1, 32'h80, 32'hCAFEF00D, 1);
`endif

        // reset while an operation is in flight
        reset_during(2'b00, 32'h0C, 32'h000000AA, 32'h11223344, "rst_rmw");
        reset_during(2'b10, 32'h0C, 32'h99999999, 32'h11223344, "rst_write");

        // bridge still works after a mid-operation reset
        issue(0, 2'b00, 1, 32'h0E, 32'h0, 32'h00000022, 0, 2, 0, 32'h0, 32'h0, 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_ram_bridge.md
Name: lsu_ram_bridge

Overview:
Load/store unit placed directly upstream of the word-wide data RAM.
- Converts core byte/halfword/word load and store requests into the RAM's 32-bit word accesses:
  - RAM read: combinational, word index = addr[31:2].
  - RAM write: synchronous, whole word, single write enable.
- Sub-word stores are done as read-modify-write.
- Loads are extracted and sign- or zero-extended. Misaligned requests are flagged as errors.

Parameters:
- RAM_SIZE, 32: RAM depth in 32-bit words; used by the range check.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  core request valid.
- req_ready  output  1  bridge can accept a request; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is an error.
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_error  output  1  qualified by rsp_valid; misaligned, bad size or out of range.
- ram_write_enable  output  1  RAM write strobe.
- ram_addr  output  32  byte address to RAM; bits [1:0] always 0.
- ram_write_data  output  32  full word to write.
- ram_read_data  input  32  combinational RAM read data.

Behaviour:
- Reset (async, rst=1): state IDLE; req_ready=1; rsp_valid, rsp_error, ram_write_enable = 0; rsp_rdata, ram_addr, ram_write_data and latched request = 0.
- Byte lanes are little-endian: byte k is at data[8k+7:8k], with k = addr[1:0].
- Handshake: a request is accepted when req_valid & req_ready at a posedge. All request fields are latched at that edge. No new request is accepted until RESP completes.
- There is no response backpressure; the core must consume rsp_valid in its cycle.
- Error checks, evaluated at acceptance:
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - req_size=11;
  - range violation (see Optional Feature).
- States:
  - IDLE: req_ready=1. On accept:
    - error -> RESP with error=1;
    - load -> LOAD;
    - word store -> WRITE, with ram_write_data = wdata;
    - byte/half store -> RMW.
  - LOAD: ram_addr = {addr[31:2],2'b00}. Capture ram_read_data, select the lane, extend into the rsp_rdata register. Go to RESP.
  - RMW: ram_addr as in LOAD. Merge ram_read_data with wdata in the addressed byte/half lane, other lanes unchanged, into ram_write_data. Go to WRITE.
  - WRITE: ram_write_enable=1 for exactly this cycle; the RAM writes at the ending edge. Go to RESP.
  - RESP: rsp_valid=1, rsp_error/rsp_rdata valid. Go to IDLE.
- Latency from the accept edge N (rsp_valid high in the cycle after edge):
  - error: N+1;
  - load: N+2;
  - word store: N+2;
  - sub-word store: N+3.
- Outputs are registered or decoded from state; ram_write_enable is never high outside WRITE.
- ram_addr holds the last latched word address in IDLE/RESP.
- Reset mid-operation: immediate return to IDLE. An outstanding request is dropped with no response. If rst rises during WRITE, ram_write_enable falls asynchronously and no RAM write occurs.

Optional Feature:
- Macro LSU_RANGE_CHECK_EN.
- Defined: a request with addr[31:2] ≥ RAM_SIZE is an error. The RAM is never accessed and the error response comes at N+1.
- Undefined: no range check; the address passes to ram_addr unchanged and behaviour beyond the RAM is the RAM's.

Test Plan:
1. Preload word 0x08 = 0x8899AABB. Signed byte load at 0x0B -> rsp_rdata 0xFFFFFF88, rsp_valid at N+2. The same load with req_unsigned=1 -> 0x00000088.
2. Half store 0x00001234 at 0x0A, word 0x08 = 0x8899AABB:
   - RMW then ram_write_enable at N+2, ram_addr 0x08, ram_write_data 0x1234AABB;
   - rsp_valid at N+3, error 0;
   - word load 0x08 -> 0x1234AABB.
3. Word store 0xDEADBEEF at 0x10 -> single write pulse in the cycle after N, rsp at N+2; load back -> 0xDEADBEEF.
4. Half load at 0x01, then word store at 0x06 -> each gives rsp_error=1 at N+1, rsp_rdata 0, no ram_write_enable.
5. Word store at 0x80 (RAM_SIZE=32):
   - with LSU_RANGE_CHECK_EN -> error at N+1, no write;
   - without -> write pulse with ram_addr 0x80, no error.
6. Byte store issued, rst asserted during RMW -> state IDLE, req_ready=1, no ram_write_enable pulse, no rsp_valid; target word unchanged.
